tt_sweep_capture: RTL and testbench

Sequential truth-table extractor for 7-input Boolean function blocks. On `start`, it drives every input vector 0..127 onto a function-under-test and samples that block's single-bit response. It then assembles the 128-bit truth table, its weight, and a match flag against an expected table, and offers the result on a valid/ready port. It sits on the opposite side of the combinational function blocks: they map inputs to one output, and this block reads a function back into its truth-table signature for classification and regression checks.

---
 rtl/tt_pkg.sv | 15 +
 rtl/tt_index_pipe.sv | 41 ++++
 rtl/tt_sweep_capture.sv | 125 ++++++++++++
 tb/tb_tt_sweep_capture.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// rtl/tt_pkg.sv - shared widths and FSM states for the truth-table sweep capture block
package tt_pkg;

  localparam int TT_NUM_INPUTS = 7;
  localparam int TT_WIDTH      = 128;
  localparam int TT_WEIGHT_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    HOLD
  } tt_state_e;

endpackage

// File: rtl/tt_index_pipe.sv
// rtl/tt_index_pipe.sv - SAMPLE_LAT-deep {valid, index} delay line; zero depth is a wire
module tt_index_pipe #(
  parameter int SAMPLE_LAT = 0,
  parameter int NUM_INPUTS = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [NUM_INPUTS-1:0] in_index,
  output logic                  out_valid,
  output logic [NUM_INPUTS-1:0] out_index
);

  localparam int W = NUM_INPUTS + 1;

  // Entry 0 is the live input; entry i is the input delayed by i cycles.
  logic [W-1:0] pipe_d [SAMPLE_LAT+1];
  logic [W-1:0] pipe_q [SAMPLE_LAT+1];

  always_comb begin
    pipe_d[0] = {in_valid, in_index};
    for (int i = 1; i <= SAMPLE_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= SAMPLE_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i <= SAMPLE_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  assign {out_valid, out_index} = pipe_d[SAMPLE_LAT];

endmodule

// File: rtl/tt_sweep_capture.sv
// rtl/tt_sweep_capture.sv - sweeps all input vectors through a function block and captures its truth table
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int NUM_INPUTS = TT_NUM_INPUTS,
  parameter int SAMPLE_LAT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [TT_WIDTH-1:0]    expected,
  output logic                   busy,
  output logic [NUM_INPUTS-1:0]  x_out,
  input  logic                   f_in,
  output logic                   tt_valid,
  input  logic                   tt_ready,
  output logic [TT_WIDTH-1:0]    tt_data,
  output logic [TT_WEIGHT_W-1:0] tt_weight,
  output logic                   match
);

  tt_state_e               state_q, state_d;
  logic [NUM_INPUTS-1:0]   idx_q, idx_d;
  logic [2:0]              drain_q, drain_d;
  logic [TT_WIDTH-1:0]     exp_q, exp_d;
  logic [TT_WIDTH-1:0]     table_q, table_d;
  logic [TT_WEIGHT_W-1:0]  weight_q, weight_d;
  logic                    match_q, match_d;

  logic                    cap_valid;
  logic [NUM_INPUTS-1:0]   cap_index;

  tt_index_pipe #(
    .SAMPLE_LAT (SAMPLE_LAT),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_index_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (state_q == SWEEP),
    .in_index  (idx_q),
    .out_valid (cap_valid),
    .out_index (cap_index)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    exp_d    = exp_q;
    table_d  = table_q;
    weight_d = weight_q;
    match_d  = match_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SWEEP;
          idx_d    = '0;
          exp_d    = expected;
          table_d  = '0;
          weight_d = '0;
          match_d  = 1'b0;
        end
      end
      SWEEP: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == '1) begin
          state_d = (SAMPLE_LAT > 0) ? DRAIN : HOLD;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == 3'(SAMPLE_LAT - 1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (tt_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The pipe is empty in IDLE, so a capture never races the clear on start.
    if (cap_valid) begin
      table_d[cap_index] = f_in;
      weight_d           = weight_q + {{(TT_WEIGHT_W-1){1'b0}}, f_in};
    end

    // Compare against the table including the final capture of this cycle.
    if (state_q != HOLD && state_d == HOLD) begin
      match_d = (table_d == exp_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      drain_q  <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      weight_q <= '0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      weight_q <= weight_d;
      match_q  <= match_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign tt_valid  = (state_q == HOLD);
  assign x_out     = (state_q == SWEEP) ? idx_q : '0;
  assign tt_data   = table_q;
  assign tt_weight = weight_q;
  assign match     = match_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// tb/tb_tt_sweep_capture.sv - self-checking bench for tt_sweep_capture at SAMPLE_LAT 0 and 2
module tb_tt_sweep_capture;
  import tt_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, tt_ready, use2;
  logic [127:0] expected;
  int           func_sel;
  logic [127:0] rand_tt;

  logic         busy0, valid0, match0, f_in0;
  logic [6:0]   x_out0;
  logic [127:0] data0;
  logic [7:0]   weight0;
  logic         busy2, valid2, match2, f_in2;
  logic [6:0]   x_out2;
  logic [127:0] data2;
  logic [7:0]   weight2;
  logic [6:0]   x_d1, x_d2;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic fut(input int sel, input logic [127:0] rt, input logic [6:0] x);
    case (sel)
      0:       return x[0];
      1:       return x[6];
      2:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
      3:       return 1'b0;
      4:       return 1'b1;
      default: return rt[x];
    endcase
  endfunction

  function automatic logic [127:0] model_tt(input int sel, input logic [127:0] rt);
    logic [127:0] t;
    for (int k = 0; k < 128; k++) t[k] = fut(sel, rt, 7'(k));
    return t;
  endfunction

  assign f_in0 = fut(func_sel, rand_tt, x_out0);
  assign f_in2 = fut(func_sel, rand_tt, x_d2);
  always @(posedge clk) begin
    x_d1 <= x_out2;
    x_d2 <= x_d1;
  end

  tt_sweep_capture #(.NUM_INPUTS(7), .SAMPLE_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start & !use2), .expected(expected),
    .busy(busy0), .x_out(x_out0), .f_in(f_in0), .tt_valid(valid0),
    .tt_ready(tt_ready & !use2), .tt_data(data0), .tt_weight(weight0), .match(match0)
  );

  tt_sweep_capture #(.NUM_INPUTS(7), .SAMPLE_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & use2), .expected(expected),
    .busy(busy2), .x_out(x_out2), .f_in(f_in2), .tt_valid(valid2),
    .tt_ready(tt_ready & use2), .tt_data(data2), .tt_weight(weight2), .match(match2)
  );

  logic         c_busy, c_valid, c_match;
  logic [6:0]   c_x;
  logic [127:0] c_data;
  logic [7:0]   c_weight;
  assign c_busy   = use2 ? busy2   : busy0;
  assign c_valid  = use2 ? valid2  : valid0;
  assign c_match  = use2 ? match2  : match0;
  assign c_x      = use2 ? x_out2  : x_out0;
  assign c_data   = use2 ? data2   : data0;
  assign c_weight = use2 ? weight2 : weight0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " x_out"}, 128'(c_x), 128'd0);
    check({tag, " busy"}, 128'(c_busy), 128'd0);
    check({tag, " tt_valid"}, 128'(c_valid), 128'd0);
    check({tag, " tt_data"}, c_data, 128'd0);
    check({tag, " tt_weight"}, 128'(c_weight), 128'd0);
    check({tag, " match"}, 128'(c_match), 128'd0);
  endtask

  task automatic run(input int sel, input bit lat2, input logic [127:0] exp_in, input int rdly,
                     input bit pulse_mid, input bit pulse_hs, input logic [127:0] want_tt,
                     input logic [7:0] want_w, input bit want_m, input string tag);
    int n;
    int lat;
    bit seen;
    logic [127:0] held;
    lat = lat2 ? 2 : 0;
    @(posedge clk); #1;
    use2 = lat2; func_sel = sel; expected = exp_in; tt_ready = (rdly == 0); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expected = ~exp_in;
    n = 1;
    check({tag, " busy after start"}, 128'(c_busy), 128'd1);
    seen = 1'b0;
    while (!seen && n < 400) begin
      if (n == 1 || n == 78 || n == 128) check({tag, " x_out"}, 128'(c_x), 128'(n - 1));
      start = (pulse_mid && n - 1 == 40);
      if (c_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      check({tag, " timeout waiting tt_valid"}, 128'(n), 128'(129 + lat));
      rst_n = 1'b0; #1; rst_n = 1'b1;
      return;
    end
    check({tag, " latency"}, 128'(n), 128'(129 + lat));
    check({tag, " tt_data"}, c_data, want_tt);
    check({tag, " tt_weight"}, 128'(c_weight), 128'(want_w));
    check({tag, " match"}, 128'(c_match), 128'(want_m));
    held = c_data;
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, 128'(c_valid), 128'd1);
      check({tag, " hold data"}, c_data, held);
    end
    tt_ready = 1'b1;
    start = pulse_hs;
    check({tag, " busy in handshake"}, 128'(c_busy), 128'd1);
    @(posedge clk); #1;
    tt_ready = 1'b0;
    start = 1'b0;
    check({tag, " valid after handshake"}, 128'(c_valid), 128'd0);
    check({tag, " busy after handshake"}, 128'(c_busy), 128'd0);
    if (pulse_hs) begin
      repeat (3) begin
        @(posedge clk); #1;
        check({tag, " stays idle"}, 128'(c_busy), 128'd0);
      end
    end
  endtask

  typedef struct {
    int           sel;
    bit           lat2;
    logic [127:0] exp_in;
    int           rdly;
    logic [127:0] want_tt;
    logic [7:0]   want_w;
    bit           want_m;
  } vec_t;

  vec_t vecs[7];
  logic [127:0] t_a, t_hi, t_e8, t_one, m, e;

  initial begin
    rst_n = 1'b0; start = 1'b0; tt_ready = 1'b0; use2 = 1'b0;
    func_sel = 0; rand_tt = '0; expected = '0;
    t_a = {32{4'hA}};
    t_hi = {{64{1'b1}}, {64{1'b0}}};
    t_e8 = {16{8'hE8}};
    t_one = '1;
    vecs[0] = '{0, 1'b0, t_a,   0,  t_a,   8'd64,  1'b1};
    vecs[1] = '{1, 1'b0, t_hi,  0,  t_hi,  8'd64,  1'b1};
    vecs[2] = '{2, 1'b1, t_e8,  0,  t_e8,  8'd64,  1'b1};
    vecs[3] = '{2, 1'b1, '0,    2,  t_e8,  8'd64,  1'b0};
    vecs[4] = '{3, 1'b0, '0,    10, '0,    8'd0,   1'b1};
    vecs[5] = '{4, 1'b1, t_one, 10, t_one, 8'h80,  1'b1};
    vecs[6] = '{4, 1'b0, '0,    10, t_one, 8'h80,  1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset lat0");
    use2 = 1'b1; #1;
    check_all_zero("reset lat2");
    use2 = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run(vecs[v].sel, vecs[v].lat2, vecs[v].exp_in, vecs[v].rdly, 1'b0, 1'b0,
          vecs[v].want_tt, vecs[v].want_w, vecs[v].want_m, $sformatf("vec%0d", v));
    end

    run(0, 1'b0, t_a, 0, 1'b1, 1'b1, t_a, 8'd64, 1'b1, "ignored starts");

    for (int r = 0; r < 8; r++) begin
      rand_tt = {$urandom, $urandom, $urandom, $urandom};
      m = model_tt(5, rand_tt);
      e = ($urandom_range(0, 1) == 1) ? m : (m ^ (128'd1 << $urandom_range(0, 127)));
      run(5, 1'($urandom_range(0, 1)), e, int'($urandom_range(0, 3)), 1'b0, 1'b0,
          m, 8'($countones(m)), (m == e), $sformatf("rand%0d", r));
    end

    // Abort a sweep with reset while x_out is 50, then check a clean restart.
    @(posedge clk); #1;
    use2 = 1'b0; func_sel = 0; expected = t_a; tt_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && x_out0 != 7'd50; i++) begin
      @(posedge clk); #1;
    end
    check("reset test reached x_out 50", 128'(x_out0), 128'd50);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(posedge clk); #1;
    check_all_zero("held in reset");
    @(negedge clk) rst_n = 1'b1;
    run(0, 1'b0, t_a, 0, 1'b0, 1'b0, t_a, 8'd64, 1'b1, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
